// File: rtl/imem_loader.sv
// Byte-stream program loader for the instruction RAM: a 2-byte word count, then
// big-endian 16-bit words. The CPU is held in reset until a clean load finishes.
//
//  state   | meaning
//  --------+----------------------------------------------------------
//  IDLE    | after reset, waiting for start
//  LEN_HI  | waiting for the high byte of the word count
//  LEN_LO  | waiting for the low byte of the word count, then range check
//  DATA_HI | waiting for the high byte of the next word
//  DATA_LO | waiting for the low byte of the next word
//  WRITE   | one-cycle write strobe to the RAM
//  DONE    | load finished; CPU released when err is clear
module imem_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_n;
    logic            err_n;
    logic [15:0]     count;
    logic [15:0]     len_full;
    logic [ADDR_W:0] addr_inc;
    logic            xfer;
    logic            len_over;
    logic            last_word;

    // addr_inc carries one extra bit so that N == DEPTH == 2**ADDR_W still compares.
    always_comb begin
        xfer      = rx_valid && rx_ready;
        len_full  = {count[15:8], rx_data};
        addr_inc  = {1'b0, mem_addr} + {{ADDR_W{1'b0}}, 1'b1};
        len_over  = 32'(len_full) > 32'(DEPTH);
        last_word = 32'(addr_inc) == 32'(count);

        state_n = state;
        err_n   = err;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_LEN_HI;
                    err_n   = 1'b0;
                end
            end
            S_LEN_HI: begin
                if (xfer) state_n = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (xfer) begin
                    if (len_full == 16'd0) begin
                        state_n = S_DONE;
                    end else if (len_over) begin
                        state_n = S_DONE;
                        err_n   = 1'b1;
                    end else begin
                        state_n = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (xfer) state_n = S_DATA_LO;
            end
            S_DATA_LO: begin
                if (xfer) state_n = S_WRITE;
            end
            S_WRITE: begin
                state_n = last_word ? S_DONE : S_DATA_HI;
            end
            S_DONE: begin
                if (start) begin
                    state_n = S_LEN_HI;
                    err_n   = 1'b0;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            err       <= 1'b0;
            rx_ready  <= 1'b0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cpu_rst   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 16'd0;
            count     <= 16'd0;
        end else begin
            state    <= state_n;
            err      <= err_n;
            rx_ready <= (state_n == S_LEN_HI) || (state_n == S_LEN_LO) ||
                        (state_n == S_DATA_HI) || (state_n == S_DATA_LO);
            busy     <= (state_n == S_LEN_HI) || (state_n == S_LEN_LO) ||
                        (state_n == S_DATA_HI) || (state_n == S_DATA_LO) ||
                        (state_n == S_WRITE);
            done     <= (state_n == S_DONE);
            cpu_rst  <= (state_n == S_DONE) && !err_n;
            mem_we   <= (state_n == S_WRITE);

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) mem_addr <= '0;
                end
                S_LEN_HI: begin
                    if (xfer) count[15:8] <= rx_data;
                end
                S_LEN_LO: begin
                    if (xfer) count[7:0] <= rx_data;
                end
                S_DATA_HI: begin
                    if (xfer) mem_wdata[15:8] <= rx_data;
                end
                S_DATA_LO: begin
                    if (xfer) mem_wdata[7:0] <= rx_data;
                end
                S_WRITE: begin
                    // Hold the last address on completion so mem_addr stays within N-1.
                    if (!last_word) mem_addr <= addr_inc[ADDR_W-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: streams hand-built programs and checks the
// write log, status outputs and CPU reset against hand-computed values.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [9:0]  la[$];
    logic [15:0] ld[$];
    bit          prev_we = 1'b0;
    int          consec = 0;

    imem_loader #(.ADDR_W(10), .DEPTH(1024)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write log taken on the falling edge, plus back-to-back strobe detection.
    always @(negedge clk) begin
        if (mem_we) begin
            la.push_back(mem_addr);
            ld.push_back(mem_wdata);
            if (prev_we) consec++;
        end
        prev_we = mem_we;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic clear_log();
        la.delete();
        ld.delete();
        consec = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int t;
        if (rnd) begin
            int gaps;
            gaps = int'($urandom_range(0, 2));
            rx_valid = 1'b0;
            for (int g = 0; g < gaps; g++) step();
        end
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        while (!rx_ready && t < 50) begin
            step();
            t++;
        end
        if (t >= 50) chk("send_timeout", 32'(rx_ready), 32'd1);
        step();
        rx_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 200) begin
            step();
            t++;
        end
        chk("wait_done", 32'(done), 32'd1);
    endtask

    initial begin
        logic [15:0] w;
        int bad;

        rst = 1'b0; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;

        // 1: reset
        repeat (3) step();
        chk("rst_rx_ready", 32'(rx_ready), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_cpu_rst", 32'(cpu_rst), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        rst = 1'b1;
        step();
        chk("idle_rx_ready", 32'(rx_ready), 0);

        // 2: basic two-word load
        clear_log();
        pulse_start();
        chk("load_busy", 32'(busy), 1);
        chk("load_cpu_rst", 32'(cpu_rst), 0);
        chk("load_rx_ready", 32'(rx_ready), 1);
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'h12, 0); send_byte(8'h34, 0);
        send_byte(8'hAB, 0); send_byte(8'hCD, 0);
        chk("latency_we", 32'(mem_we), 1);
        chk("latency_addr", 32'(mem_addr), 1);
        chk("latency_data", 32'(mem_wdata), 32'hABCD);
        wait_done();
        chk("load_nwrites", 32'(la.size()), 2);
        chk("load_a0", 32'(la[0]), 0);
        chk("load_d0", 32'(ld[0]), 32'h1234);
        chk("load_a1", 32'(la[1]), 1);
        chk("load_d1", 32'(ld[1]), 32'hABCD);
        chk("load_cpu_run", 32'(cpu_rst), 1);
        chk("load_busy_end", 32'(busy), 0);
        chk("load_err", 32'(err), 0);
        step();
        chk("done_rx_ready", 32'(rx_ready), 0);

        // 3 + 6: restart from DONE, backpressure, start ignored mid-load
        clear_log();
        pulse_start();
        chk("restart_done", 32'(done), 0);
        chk("restart_cpu_rst", 32'(cpu_rst), 0);
        send_byte(8'h00, 1); send_byte(8'h02, 1);
        pulse_start();
        chk("ignored_start_busy", 32'(busy), 1);
        send_byte(8'h12, 1); send_byte(8'h34, 1);
        send_byte(8'hAB, 1); send_byte(8'hCD, 1);
        wait_done();
        chk("bp_nwrites", 32'(la.size()), 2);
        chk("bp_a0", 32'(la[0]), 0);
        chk("bp_d0", 32'(ld[0]), 32'h1234);
        chk("bp_a1", 32'(la[1]), 1);
        chk("bp_d1", 32'(ld[1]), 32'hABCD);
        chk("bp_consec_we", 32'(consec), 0);

        // 4a: N = 0
        clear_log();
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        wait_done();
        step();
        chk("n0_nwrites", 32'(la.size()), 0);
        chk("n0_cpu_rst", 32'(cpu_rst), 1);
        chk("n0_err", 32'(err), 0);

        // 4b: N = DEPTH, word i = 3*i + 7
        clear_log();
        pulse_start();
        send_byte(8'h04, 0); send_byte(8'h00, 0);
        for (int i = 0; i < 1024; i++) begin
            w = 16'(i * 3 + 7);
            send_byte(w[15:8], 0);
            send_byte(w[7:0], 0);
        end
        wait_done();
        chk("depth_nwrites", 32'(la.size()), 1024);
        chk("depth_last_addr", 32'(la[1023]), 1023);
        chk("depth_last_data", 32'(ld[1023]), 32'(16'(1023 * 3 + 7)));
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            if (la[i] !== 10'(i) || ld[i] !== 16'(i * 3 + 7)) bad++;
        end
        chk("depth_all_words", 32'(bad), 0);
        chk("depth_cpu_rst", 32'(cpu_rst), 1);
        chk("depth_consec_we", 32'(consec), 0);

        // 4c: N = DEPTH+1 rejected
        clear_log();
        pulse_start();
        send_byte(8'h04, 0); send_byte(8'h01, 0);
        wait_done();
        step();
        chk("over_err", 32'(err), 1);
        chk("over_cpu_rst", 32'(cpu_rst), 0);
        chk("over_nwrites", 32'(la.size()), 0);

        // 6: start from DONE clears err; new load writes from address 0
        pulse_start();
        chk("clr_err", 32'(err), 0);
        chk("clr_done", 32'(done), 0);
        chk("clr_cpu_rst", 32'(cpu_rst), 0);
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'hBE, 0); send_byte(8'hEF, 0);
        wait_done();
        chk("clr_nwrites", 32'(la.size()), 1);
        chk("clr_a0", 32'(la[0]), 0);
        chk("clr_d0", 32'(ld[0]), 32'hBEEF);
        chk("clr_cpu_run", 32'(cpu_rst), 1);

        // 5: reset after the second of four writes
        clear_log();
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h04, 0);
        send_byte(8'h11, 0); send_byte(8'h11, 0);
        send_byte(8'h22, 0); send_byte(8'h22, 0);
        step();
        rst = 1'b0;
        step();
        chk("mid_busy", 32'(busy), 0);
        chk("mid_cpu_rst", 32'(cpu_rst), 0);
        chk("mid_rx_ready", 32'(rx_ready), 0);
        chk("mid_addr", 32'(mem_addr), 0);
        chk("mid_done", 32'(done), 0);
        chk("mid_nwrites", 32'(la.size()), 2);
        chk("mid_a1", 32'(la[1]), 1);
        rst = 1'b1;
        step();
        clear_log();
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'h55, 0); send_byte(8'hAA, 0);
        wait_done();
        chk("reload_nwrites", 32'(la.size()), 1);
        chk("reload_a0", 32'(la[0]), 0);
        chk("reload_d0", 32'(ld[0]), 32'h55AA);
        chk("reload_cpu_run", 32'(cpu_rst), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
